// File: rtl/mem_bus_ctrl.sv
// Word-to-byte memory bus bridge: one 32-bit request becomes four big-endian byte accesses, WAIT+1 cycles each.
// Latency 4*(WAIT+1)+1 cycles to done (1 for out-of-range); requests arriving while busy are dropped, not queued.
module mem_bus_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int MEM_SIZE = 128,
  parameter int WAIT     = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m_en,
  input  logic              m_rw,
  input  logic [ADDR_W-1:0] abus,
  input  logic [31:0]       dbus_in,
  output logic [31:0]       dbus_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] b_addr,
  output logic [7:0]        b_wdata,
  input  logic [7:0]        b_rdata,
  output logic              b_en,
  output logic              b_we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W+1)'(MEM_SIZE);
  localparam logic [3:0]      WAIT_L = 4'(WAIT);

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [31:0]         wdata_q;
  logic                rw_q;
  logic [1:0]          k_q;
  logic [3:0]          wcnt_q;
  logic [31:0]         rshift_q;

  logic [ADDR_W:0]     end_addr;
  logic                out_of_range;
  logic                byte_last;
  logic [31:0]         rword;

  // One extra bit keeps the last-byte address from wrapping near the top of the space.
  assign end_addr     = {1'b0, abus} + {{(ADDR_W-1){1'b0}}, 2'd3};
  assign out_of_range = (end_addr >= LIMIT);
  assign byte_last    = (wcnt_q == WAIT_L);
  assign rword        = {rshift_q[23:0], b_rdata};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      base_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      k_q      <= '0;
      wcnt_q   <= '0;
      rshift_q <= '0;
      dbus_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      b_addr   <= '0;
      b_wdata  <= '0;
      b_en     <= 1'b0;
      b_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (m_en) begin
            base_q  <= abus;
            wdata_q <= dbus_in;
            rw_q    <= m_rw;
            k_q     <= '0;
            wcnt_q  <= '0;
            busy    <= 1'b1;
            if (out_of_range) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state   <= XFER;
              b_en    <= 1'b1;
              b_addr  <= abus;
              b_we    <= ~m_rw;
              b_wdata <= dbus_in[31:24];
            end
          end
        end

        XFER: begin
          if (!byte_last) begin
            wcnt_q <= wcnt_q + 4'd1;
          end else begin
            wcnt_q <= '0;
            // Bytes arrive MSB first, so shifting left leaves byte 0 in the top lane.
            if (rw_q) begin
              rshift_q <= rword;
            end
            if (k_q == 2'd3) begin
              state <= DONE;
              b_en  <= 1'b0;
              b_we  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b0;
              if (rw_q) begin
                dbus_out <= rword;
              end
            end else begin
              k_q     <= k_q + 2'd1;
              b_addr  <= base_q + ADDR_W'(k_q) + ADDR_W'(1);
              b_wdata <= wdata_q[23:16];
              wdata_q <= {wdata_q[23:0], 8'h00};
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          b_en  <= 1'b0;
          b_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (WAIT=0 and WAIT=2) against a byte-array memory model and expectation queues.
module tb_mem_bus_ctrl;
  localparam int AW = 32;
  localparam int MS = 128;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          m_en0 = 1'b0, m_en2 = 1'b0;
  logic          m_rw = 1'b0;
  logic [AW-1:0] abus = '0;
  logic [31:0]   dbus_in = '0;

  logic [31:0]   dout0, dout2;
  logic          busy0, busy2, done0, done2, err0, err2;
  logic [AW-1:0] ba0, ba2;
  logic [7:0]    bw0, bw2, rd0, rd2;
  logic          ben0, ben2, bwe0, bwe2;

  logic [7:0] ram     [MS];
  logic [7:0] ref_mem [MS];

  assign rd0 = ram[ba0[6:0]];
  assign rd2 = ram[ba2[6:0]];

  always @(posedge clock) begin
    if (ben0 && bwe0) ram[ba0[6:0]] <= bw0;
    if (ben2 && bwe2) ram[ba2[6:0]] <= bw2;
  end

  mem_bus_ctrl #(.ADDR_W(AW), .MEM_SIZE(MS), .WAIT(0)) u0 (
    .clock(clock), .reset(reset), .m_en(m_en0), .m_rw(m_rw), .abus(abus),
    .dbus_in(dbus_in), .dbus_out(dout0), .busy(busy0), .done(done0), .err(err0),
    .b_addr(ba0), .b_wdata(bw0), .b_rdata(rd0), .b_en(ben0), .b_we(bwe0));

  mem_bus_ctrl #(.ADDR_W(AW), .MEM_SIZE(MS), .WAIT(2)) u2 (
    .clock(clock), .reset(reset), .m_en(m_en2), .m_rw(m_rw), .abus(abus),
    .dbus_in(dbus_in), .dbus_out(dout2), .busy(busy2), .done(done2), .err(err2),
    .b_addr(ba2), .b_wdata(bw2), .b_rdata(rd2), .b_en(ben2), .b_we(bwe2));

  // Only one instance is exercised at a time; sel picks which one the monitor watches.
  logic          sel = 1'b0;
  logic [31:0]   m_dout;
  logic          m_busy, m_done, m_err, m_ben, m_bwe;
  logic [AW-1:0] m_ba;
  logic [7:0]    m_bw;
  assign m_dout = sel ? dout2 : dout0;
  assign m_busy = sel ? busy2 : busy0;
  assign m_done = sel ? done2 : done0;
  assign m_err  = sel ? err2  : err0;
  assign m_ben  = sel ? ben2  : ben0;
  assign m_bwe  = sel ? bwe2  : bwe0;
  assign m_ba   = sel ? ba2   : ba0;
  assign m_bw   = sel ? bw2   : bw0;

  typedef struct packed {
    int          acc;
    int          dcyc;
    logic        err;
    logic        upd;
    logic [31:0] dout;
  } resp_t;

  typedef struct packed {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wd;
  } bus_t;

  resp_t rq[$];
  bus_t  bq[$];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_dout = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d, wait_inst %0d)", nm, act, expv, cyc, sel ? 2 : 0);
    end
  endtask

  // Monitor: compares every cycle against whatever the queues say should be happening now.
  logic exp_busy;
  always @(negedge clock) begin
    if (reset) begin
      exp_busy = (rq.size() > 0) && (cyc >= rq[0].acc);
      chk("busy", {31'd0, m_busy}, {31'd0, exp_busy});
      if (bq.size() > 0 && bq[0].cyc == cyc) begin
        chk("b_en", {31'd0, m_ben}, 32'd1);
        chk("b_addr", m_ba, bq[0].addr);
        chk("b_we", {31'd0, m_bwe}, {31'd0, bq[0].we});
        if (bq[0].we) chk("b_wdata", {24'd0, m_bw}, {24'd0, bq[0].wd});
        void'(bq.pop_front());
      end else begin
        chk("b_en_idle", {31'd0, m_ben}, 32'd0);
      end
      if (rq.size() > 0 && rq[0].dcyc == cyc) begin
        chk("done", {31'd0, m_done}, 32'd1);
        chk("err", {31'd0, m_err}, {31'd0, rq[0].err});
        if (rq[0].upd) exp_dout = rq[0].dout;
        void'(rq.pop_front());
      end else begin
        chk("done_idle", {31'd0, m_done}, 32'd0);
        chk("err_idle", {31'd0, m_err}, 32'd0);
      end
      chk("dbus_out", m_dout, exp_dout);
    end
  end

  // Reference: a request is four consecutive bytes, MSB at the lowest address.
  task automatic push_req(input logic rw, input logic [31:0] a, input logic [31:0] d, input int acc);
    resp_t r;
    bus_t  b;
    int    w;
    w = sel ? 2 : 0;
    r.acc  = acc;
    r.err  = 1'b0;
    r.upd  = 1'b0;
    r.dout = '0;
    if (longint'(a) + 3 >= MS) begin
      r.err  = 1'b1;
      r.dcyc = acc;
    end else begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j <= w; j++) begin
          b.cyc  = acc + k * (w + 1) + j;
          b.addr = a + k;
          b.we   = ~rw;
          b.wd   = d[31 - 8*k -: 8];
          bq.push_back(b);
        end
        if (rw) r.dout = {r.dout[23:0], ref_mem[int'(a) + k]};
        else    ref_mem[int'(a) + k] = d[31 - 8*k -: 8];
      end
      r.upd  = rw;
      r.dcyc = acc + 4 * (w + 1);
    end
    rq.push_back(r);
  endtask

  task automatic set_en(input logic v);
    if (sel) m_en2 = v;
    else     m_en0 = v;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rq.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (rq.size() > 0) begin
      failures++;
      $display("FAIL timeout: %0d responses outstanding, required 0", rq.size());
      rq.delete();
      bq.delete();
    end
  endtask

  task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    m_rw = rw; abus = a; dbus_in = d;
    set_en(1'b1);
    push_req(rw, a, d, cyc + 1);
    @(negedge clock);
    set_en(1'b0);
    wait_idle();
  endtask

  int          c0;
  logic [31:0] ra;
  int          rsel;

  initial begin
    for (int i = 0; i < MS; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    #1;
    chk("rst_dout0", dout0, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_done0", {31'd0, done0}, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_ben0", {31'd0, ben0}, 32'd0);
    chk("rst_bwe0", {31'd0, bwe0}, 32'd0);
    chk("rst_baddr0", ba0, 32'd0);
    chk("rst_bwdata0", {24'd0, bw0}, 32'd0);
    chk("rst_dout2", dout2, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    @(negedge clock);
    #2 reset = 1'b1;

    // WAIT=0 directed
    sel = 1'b0;
    req(1'b0, 32'h0C, 32'h13221000);
    req(1'b1, 32'h0C, 32'h0);
    req(1'b1, 32'd126, 32'h0);
    req(1'b1, 32'd125, 32'h0);
    req(1'b0, 32'hFFFF_FFFE, 32'hDEADBEEF);
    req(1'b1, 32'd124, 32'h0);
    req(1'b0, 32'd124, 32'hA1B2C3D4);
    req(1'b1, 32'd124, 32'h0);
    req(1'b1, 32'h0D, 32'h0);

    // m_en held 10 cycles; abus and direction change mid-transfer
    @(negedge clock);
    c0 = cyc;
    m_rw = 1'b0; abus = 32'h20; dbus_in = 32'hCAFEF00D;
    m_en0 = 1'b1;
    push_req(1'b0, 32'h20, 32'hCAFEF00D, c0 + 1);
    repeat (2) @(negedge clock);
    m_rw = 1'b1; abus = 32'h21; dbus_in = 32'h55555555;
    push_req(1'b1, 32'h21, 32'h0, c0 + 7);
    while (cyc < c0 + 10) @(negedge clock);
    m_en0 = 1'b0;
    wait_idle();

    // Reset during byte 2 of a write
    @(negedge clock);
    c0 = cyc;
    m_rw = 1'b0; abus = 32'h40; dbus_in = 32'h89ABCDEF;
    m_en0 = 1'b1;
    push_req(1'b0, 32'h40, 32'h89ABCDEF, c0 + 1);
    @(negedge clock);
    m_en0 = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_ben", {31'd0, ben0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    chk("abort_dout", dout0, 32'd0);
    rq.delete();
    bq.delete();
    exp_dout = '0;
    repeat (2) @(negedge clock);
    chk("abort_no_done", {31'd0, done0}, 32'd0);
    #2 reset = 1'b1;
    req(1'b0, 32'h40, 32'h89ABCDEF);
    req(1'b1, 32'h40, 32'h0);

    // Randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      exp_dout = sel ? dout2 : dout0;
      if (sel) begin
        req(1'b0, 32'h1C, 32'h00000001);
        req(1'b1, 32'h1C, 32'h0);
        chk("wait2_read", exp_dout, 32'h00000001);
      end
      for (int i = 0; i < 40; i++) begin
        rsel = $urandom_range(0, 9);
        if (rsel == 0)      ra = $urandom_range(125, 140);
        else if (rsel == 1) ra = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        else                ra = $urandom_range(0, 124);
        req(1'($urandom), ra, $urandom);
      end
    end

    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory bus controller between the CPU0 core's word-wide memory port (m_en, m_rw, mar, mdr, dbus) and a byte-wide RAM.
- Accepts one 32-bit read or write per request.
- Performs four big-endian byte transfers with a configurable number of wait states.
- Returns the assembled read word and a one-cycle done pulse.
- Flags out-of-range addresses without touching the RAM.

Parameters:
ADDR_W, 32, width of word address and byte address buses
MEM_SIZE, 128, RAM size in bytes; valid word requests need abus+3 < MEM_SIZE
WAIT, 0, extra wait cycles per byte transfer (0..15)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
m_en  input  1  request strobe from CPU (level, sampled in IDLE)
m_rw  input  1  1 = read, 0 = write
abus  input  ADDR_W  word byte-address (CPU mar)
dbus_in  input  32  write data (CPU mdr)
dbus_out  output  32  last completed read word
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse coincident with done on out-of-range request
b_addr  output  ADDR_W  RAM byte address
b_wdata  output  8  RAM write byte
b_rdata  input  8  RAM read byte
b_en  output  1  RAM access enable
b_we  output  1  RAM write enable (1 = write)

Behaviour:
- Reset (reset=0, async): state=IDLE; dbus_out=0; busy=0; done=0; err=0; b_en=0; b_we=0; b_addr=0; b_wdata=0. Takes effect immediately, including mid-transfer. Any in-flight request is abandoned with no done pulse.
- States: IDLE, XFER, DONE.
- IDLE: on a clock edge with m_en=1, latch abus, dbus_in and m_rw into internal registers.
  - If abus+3 >= MEM_SIZE (unsigned, computed in ADDR_W+1 bits so there is no wrap): go to DONE with an error flag set.
  - Otherwise: go to XFER with byte index k=0 and wait counter=0.
- XFER, byte k (0..3):
  - b_en=1; b_addr=base+k; b_we=~rw.
  - b_wdata = wdata[31-8k : 24-8k], so k=0 is the MSB (big-endian, matching the memory image layout).
  - Each byte is held for WAIT+1 cycles. Outputs are stable for the whole byte.
  - On the final cycle of a read byte, b_rdata is sampled at the clock edge into shift-register byte k.
  - After k=3 completes, go to DONE.
  - b_en=0 outside XFER.
- DONE: lasts one cycle. done=1, and err=error flag.
  - For a successful read, dbus_out takes the assembled word on entry to DONE.
  - Writes and errors leave dbus_out unchanged.
  - Next state is IDLE.
- Latency: request sampled at edge E0. done is high in cycle 4*(WAIT+1)+1 after E0 (5 cycles for WAIT=0). For an error request, done is high in cycle 1.
- Requests while busy: m_en and the inputs are ignored. They are not queued.
- Back-to-back: if m_en is still high in IDLE after DONE, a new request is accepted at that edge. There is a minimum of one IDLE cycle between requests.
- dbus_out is held between reads. It is never high-impedance.
- There is no alignment check. Unaligned base addresses are legal if they are in range.

Test Plan:
- WAIT=0, write abus=0x0C, dbus_in=0x13221000 -> b_addr 0C,0D,0E,0F in cycles 1-4 with b_wdata 13,22,10,00 and b_we=1; done=1, err=0 in cycle 5; busy=1 cycles 1-5.
- Then read abus=0x0C with b_rdata returning the stored bytes -> b_we=0, dbus_out=0x13221000 on the done cycle, and held afterwards.
- WAIT=2, read abus=0x1C with bytes 00,00,00,01 -> each b_addr held 3 cycles; done in cycle 13; dbus_out=0x00000001.
- MEM_SIZE=128, read abus=126 -> no b_en activity; done=1 and err=1 in cycle 1; dbus_out unchanged. abus=124 is accepted with err=0.
- Assert reset low during byte k=2 of a write -> b_en=0 and state=IDLE immediately, with no done pulse; after release, a new request completes normally.
- Hold m_en=1 for 10 cycles with abus changed mid-transfer -> first transfer uses the latched address; a second request is accepted in the IDLE cycle after done using the abus value present then.
